// File: rtl/even_updown_checker.sv
// Receive-side monitor for the 4-bit even up/down counter. Samples q/y every
// enabled clock, checks each step against the even sequence (step of 2 in the
// direction in force when the previous sample was taken), counts errors and
// re-locks after a run of legal transitions.
//
//  state | meaning
//  ------+-----------------------------------------------------------
//  SYNC  | waiting for first enabled sample; capture only, no check
//  TRACK | locked; every mismatch pulses err and bumps err_cnt
//  FAULT | unlocked; re-tracking observed stream, counting legal steps
//  11    | unused; recovers to SYNC
module even_updown_checker #(
    parameter int WIDTH      = 4,
    parameter int ERR_CNT_W  = 8,
    parameter int RESYNC_LEN = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic [WIDTH-1:0]     q,
    input  logic                 y,
    output logic                 locked,
    output logic                 err,
    output logic                 odd_err,
    output logic                 wrap,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic [1:0]           state
);

    typedef enum logic [1:0] {
        SYNC   = 2'b00,
        TRACK  = 2'b01,
        FAULT  = 2'b10,
        UNUSED = 2'b11
    } state_t;

    localparam int RUN_W = (RESYNC_LEN < 2) ? 1 : $clog2(RESYNC_LEN + 1);
    localparam logic [WIDTH-1:0] STEP = WIDTH'(2);
    localparam logic [WIDTH-1:0] TOP  = {{(WIDTH-1){1'b1}}, 1'b0};
    localparam logic [RUN_W-1:0] RUN_DONE = RUN_W'(RESYNC_LEN);

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     last_val_q, last_val_d;
    logic                 last_dir_q, last_dir_d;
    logic [RUN_W-1:0]     good_run_q, good_run_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic                 err_q, err_d;
    logic                 odd_err_q, odd_err_d;
    logic                 wrap_q, wrap_d;

    logic [WIDTH-1:0]     expected;
    logic                 match;
    logic                 wrap_hit;
    logic [RUN_W-1:0]     run_inc;

    // Expected next value from the last sample, and the boundary-crossing flag.
    always_comb begin
        expected = last_dir_q ? (last_val_q + STEP) : (last_val_q - STEP);
        match    = (q == expected) && (q[0] == 1'b0);
        wrap_hit = (last_dir_q && (last_val_q == TOP) && (q == '0)) ||
                   (!last_dir_q && (last_val_q == '0) && (q == TOP));
        run_inc  = good_run_q + RUN_W'(1);
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        last_val_d = last_val_q;
        last_dir_d = last_dir_q;
        good_run_d = good_run_q;
        err_cnt_d  = err_cnt_q;
        err_d      = 1'b0;
        odd_err_d  = 1'b0;
        wrap_d     = 1'b0;

        if (!en) begin
            // Gap in sampling: the next enabled sample is a fresh capture.
            state_d = SYNC;
        end else begin
            last_val_d = q;
            last_dir_d = y;
            odd_err_d  = q[0];
            case (state_q)
                SYNC: begin
                    state_d = TRACK;
                end
                TRACK: begin
                    if (match) begin
                        wrap_d = wrap_hit;
                    end else begin
                        err_d      = 1'b1;
                        good_run_d = '0;
                        state_d    = FAULT;
                        if (err_cnt_q != '1) begin
                            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
                        end
                    end
                end
                FAULT: begin
                    if (match) begin
                        if (run_inc == RUN_DONE) begin
                            good_run_d = '0;
                            state_d    = TRACK;
                        end else begin
                            good_run_d = run_inc;
                        end
                    end else begin
                        good_run_d = '0;
                    end
                end
                default: begin
                    state_d = SYNC;
                end
            endcase
        end
    end

    // State and sample registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= SYNC;
            last_val_q <= '0;
            last_dir_q <= 1'b0;
            good_run_q <= '0;
            err_cnt_q  <= '0;
            err_q      <= 1'b0;
            odd_err_q  <= 1'b0;
            wrap_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_val_q <= last_val_d;
            last_dir_q <= last_dir_d;
            good_run_q <= good_run_d;
            err_cnt_q  <= err_cnt_d;
            err_q      <= err_d;
            odd_err_q  <= odd_err_d;
            wrap_q     <= wrap_d;
        end
    end

    assign locked  = (state_q == TRACK);
    assign err     = err_q;
    assign odd_err = odd_err_q;
    assign wrap    = wrap_q;
    assign err_cnt = err_cnt_q;
    assign state   = state_q;

endmodule
